// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage in front of a synchronous instruction
//               memory. Owns the program counter, drives the memory address
//               and registers the returned word into the fetch/decode stage
//               with its PC and a valid flag. Supports decode stalls, jump
//               redirects with a one-bubble flush and a HALT opcode that
//               freezes fetch until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
  parameter logic [DATA_W-1:0] NOP_INSTR   = 32'h00000000,
  parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              JMP_EN,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [DATA_W-1:0] IMEM_DATA,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  output logic              HALTED
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;        // next address to fetch
  logic [ADDR_W-1:0] pc_d;      // address whose word is currently on IMEM_DATA
  logic              rd_valid;  // pc_d refers to a real outstanding read
  logic [ADDR_W-1:0] addr_mux;
  logic              is_halt_word;

  assign is_halt_word = (IMEM_DATA[DATA_W-1 -: 8] == HALT_OPCODE);

  // Memory address select: jump target first, then re-read of the pending
  // address while stalled (so its word is still on IMEM_DATA after the stall),
  // otherwise the sequential PC. A halted unit just parks on pc.
  always_comb begin
    addr_mux = pc;
    if (state == RUN) begin
      if (JMP_EN) begin
        addr_mux = JMP_ADDR;
      end else if (STALL && rd_valid) begin
        addr_mux = pc_d;
      end
    end
  end

  assign IMEM_ADDR = addr_mux;
  assign HALTED    = (state == HALT);

  // Fetch state machine: PC advance, pipeline-register capture and halt entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pc_d        <= '0;
      rd_valid    <= 1'b0;
      INSTR       <= NOP_INSTR;
      INSTR_PC    <= '0;
      INSTR_VALID <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (JMP_EN) begin
            // Redirect: the word in flight is from the old stream, squash it.
            pc          <= JMP_ADDR + PC_ONE;
            pc_d        <= JMP_ADDR;
            rd_valid    <= 1'b1;
            INSTR       <= NOP_INSTR;
            INSTR_VALID <= 1'b0;
          end else if (!STALL) begin
            pc          <= pc + PC_ONE;
            pc_d        <= pc;
            rd_valid    <= 1'b1;
            INSTR       <= rd_valid ? IMEM_DATA : NOP_INSTR;
            INSTR_PC    <= pc_d;
            INSTR_VALID <= rd_valid;
            // The halt word itself is delivered; fetch stops from here on.
            if (rd_valid && is_halt_word) begin
              state <= HALT;
            end
          end
        end
        HALT: begin
          rd_valid    <= 1'b0;
          INSTR       <= NOP_INSTR;
          INSTR_VALID <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A vector table drives
//               STALL/JMP/RST per cycle with expected valid/halted/address;
//               expected (PC, word) pairs go into a scoreboard queue and are
//               popped whenever the DUT presents a valid instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        STALL;
  logic        JMP_EN;
  logic [7:0]  JMP_ADDR;
  logic [7:0]  IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic [31:0] INSTR;
  logic [7:0]  INSTR_PC;
  logic        INSTR_VALID;
  logic        HALTED;

  fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .STALL      (STALL),
    .JMP_EN     (JMP_EN),
    .JMP_ADDR   (JMP_ADDR),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_DATA  (IMEM_DATA),
    .INSTR      (INSTR),
    .INSTR_PC   (INSTR_PC),
    .INSTR_VALID(INSTR_VALID),
    .HALTED     (HALTED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous instruction memory model
  logic [31:0] mem [256];
  initial IMEM_DATA = 32'h0;
  always @(posedge CLK) IMEM_DATA <= mem[IMEM_ADDR];

  typedef struct packed {
    logic       rst;
    logic       stall;
    logic       jmp;
    logic [7:0] jaddr;
    logic       chk;     // check IMEM_ADDR before the edge
    logic [7:0] eaddr;
    logic       ev;      // expected INSTR_VALID after the edge
    logic [7:0] epc;
    logic       eh;      // expected HALTED after the edge
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  function automatic void add(input logic s, input logic j, input logic [7:0] ja,
                              input logic c, input logic [7:0] ea,
                              input logic ev, input logic [7:0] ep, input logic eh);
    vec_t v;
    v.rst = 1'b0; v.stall = s; v.jmp = j; v.jaddr = ja;
    v.chk = c; v.eaddr = ea; v.ev = ev; v.epc = ep; v.eh = eh;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst();
    vec_t v;
    v = '0;
    v.rst = 1'b1;
    vecs.push_back(v);
  endfunction

  function automatic void add_run(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) add(0, 0, 8'h00, 0, 8'h00, 1, 8'(start + i), 0);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    @(negedge CLK);
    RST = v.rst; STALL = v.stall; JMP_EN = v.jmp; JMP_ADDR = v.jaddr;
    #1;
    if (v.rst) begin
      // Reset acts immediately, mid-cycle
      check("rst_valid", idx, 32'(INSTR_VALID), 32'h0);
      check("rst_halted", idx, 32'(HALTED), 32'h0);
      check("rst_instr", idx, INSTR, 32'h0);
      check("rst_pc", idx, 32'(INSTR_PC), 32'h0);
      sb.delete();
    end else begin
      if (v.chk) check("imem_addr", idx, 32'(IMEM_ADDR), 32'(v.eaddr));
      if (v.ev) sb.push_back('{v.epc, mem[v.epc]});
      @(posedge CLK);
      #1;
      check("valid", idx, 32'(INSTR_VALID), 32'(v.ev));
      check("halted", idx, 32'(HALTED), 32'(v.eh));
      if (INSTR_VALID) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_instr step %0d: got pc %0h, expected none", idx, INSTR_PC);
        end else begin
          e = sb.pop_front();
          check("instr_pc", idx, 32'(INSTR_PC), 32'(e.pc));
          check("instr", idx, INSTR, e.word);
        end
      end else begin
        check("nop_instr", idx, INSTR, 32'h0);
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; STALL = 1'b0; JMP_EN = 1'b0; JMP_ADDR = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

    // Sequential fetch from reset, then a 3-cycle stall at INSTR_PC=5
    add_rst();
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    add_run(8'h00, 6);
    for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 1, 8'h06, 1, 8'h05, 0);
    add(0, 0, 8'h00, 1, 8'h07, 1, 8'h06, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h07, 0);
    // Jump to 0x40 while INSTR_PC=3, without and with a simultaneous stall
    for (int s = 0; s < 2; s++) begin
      add_rst();
      add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
      add_run(8'h00, 4);
      add(s[0], 1, 8'h40, 1, 8'h40, 0, 8'h00, 0);
      add_run(8'h40, 2);
    end
    // Wrap-around: sequential across 0xFF, then jump to 0xFF
    add_rst();
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    add_run(8'h00, 1);
    add(0, 1, 8'hFE, 1, 8'hFE, 0, 8'h00, 0);
    add_run(8'hFE, 4);
    add(0, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, 0);
    add_run(8'hFF, 2);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // HALT word at address 10
    vecs.delete();
    mem[10] = 32'hFF00_0000;
    add_rst();
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    add_run(8'h00, 10);
    add(0, 0, 8'h00, 1, 8'h0B, 1, 8'h0A, 1);
    add(0, 1, 8'h20, 1, 8'h0C, 0, 8'h00, 1);
    add(1, 1, 8'h30, 1, 8'h0C, 0, 8'h00, 1);
    add(0, 0, 8'h00, 1, 8'h0C, 0, 8'h00, 1);
    add_rst();
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    add_run(8'h00, 2);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1000 + i);

    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
